// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC XOR global history indexes saturating counters; post-reset sweep clears the table.
// Define BP_STATS_EN to add saturating resolved-branch / mispredict counters on the stat_* ports.
module gshare_predictor #(
   parameter int INDEX_BITS = 5,
   parameter int HIST_BITS  = 4,
   parameter int CTR_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [15:0]          pc_id,
   input  logic [3:0]           opcode_id,
   input  logic                 advance_id,
   output logic                 predict_taken,
   output logic [HIST_BITS-1:0] branch_hist_id,
   output logic                 ready,
   input  logic                 resolve_valid,
   input  logic [15:0]          pc_wb,
   input  logic                 resolve_taken,
   input  logic                 resolve_mispredict,
   input  logic [HIST_BITS-1:0] branch_hist_wb,
   output logic [15:0]          stat_branches,
   output logic [15:0]          stat_mispredicts
);

   localparam int                    ENTRIES  = 1 << INDEX_BITS;
   localparam logic [3:0]            OP_BR    = 4'b0000;
   localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
   localparam logic [INDEX_BITS-1:0] PTR_LAST = INDEX_BITS'(ENTRIES - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   // History occupies the top HIST_BITS of the index; written as a shift so HIST_BITS == INDEX_BITS works.
   function automatic logic [INDEX_BITS-1:0] hash_idx(input logic [15:0]          pc,
                                                      input logic [HIST_BITS-1:0] hist);
      logic [INDEX_BITS-1:0] hist_ext;
      hist_ext = INDEX_BITS'(hist) << (INDEX_BITS - HIST_BITS);
      return pc[INDEX_BITS:1] ^ hist_ext;
   endfunction

   // Shift left with the new outcome in the LSB; also correct for HIST_BITS == 1.
   function automatic logic [HIST_BITS-1:0] hist_push(input logic [HIST_BITS-1:0] hist,
                                                       input logic                 bit_in);
      return HIST_BITS'({hist, bit_in});
   endfunction

   state_e                state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [HIST_BITS-1:0]  spec_hist_q, spec_hist_d;
   logic [CTR_BITS-1:0]   tbl_q [ENTRIES];

   logic                  run;
   logic                  br_id;
   logic [INDEX_BITS-1:0] idx_id, idx_wb;
   logic [CTR_BITS-1:0]   ctr_id, ctr_wb;
   logic [CTR_BITS-1:0]   ctr_inc, ctr_dec;
   logic                  tbl_we;
   logic [INDEX_BITS-1:0] tbl_waddr;
   logic [CTR_BITS-1:0]   tbl_wdata;

   // Two combinational read ports: ID lookup and WB read-modify-write.
   always_comb begin
      run     = (state_q == ST_RUN);
      br_id   = (opcode_id == OP_BR);
      idx_id  = hash_idx(pc_id, spec_hist_q);
      idx_wb  = hash_idx(pc_wb, branch_hist_wb);
      ctr_id  = tbl_q[idx_id];
      ctr_wb  = tbl_q[idx_wb];
      ctr_inc = (ctr_wb == CTR_MAX) ? ctr_wb : ctr_wb + 1'b1;
      ctr_dec = (ctr_wb == '0)      ? ctr_wb : ctr_wb - 1'b1;
   end

   assign predict_taken  = run & br_id & ctr_id[CTR_BITS-1];
   assign branch_hist_id = spec_hist_q;
   assign ready          = run;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      tbl_we    = 1'b0;
      tbl_waddr = ptr_q;
      tbl_wdata = CTR_WNT;
      if (clear) begin
         state_d = ST_INIT;
         ptr_d   = '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               tbl_we = 1'b1;
               ptr_d  = ptr_q + 1'b1;
               if (ptr_q == PTR_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (resolve_valid) begin
                  tbl_we    = 1'b1;
                  tbl_waddr = idx_wb;
                  tbl_wdata = resolve_taken ? ctr_inc : ctr_dec;
               end
            end
            default: state_d = ST_INIT;
         endcase
      end
   end

   // A mispredict squashes the ID instruction, so repair wins over the speculative shift.
   always_comb begin
      spec_hist_d = spec_hist_q;
      if (clear) begin
         spec_hist_d = '0;
      end else if (run) begin
         if (resolve_valid && resolve_mispredict)
            spec_hist_d = hist_push(branch_hist_wb, resolve_taken);
         else if (advance_id && br_id)
            spec_hist_d = hist_push(spec_hist_q, predict_taken);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         ptr_q       <= '0;
         spec_hist_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         spec_hist_q <= spec_hist_d;
      end
   end

   // Table contents are defined by the sweep, so no reset here.
   always_ff @(posedge clk) begin
      if (tbl_we) tbl_q[tbl_waddr] <= tbl_wdata;
   end

`ifdef BP_STATS_EN
   logic [15:0] stat_br_q, stat_br_d;
   logic [15:0] stat_mis_q, stat_mis_d;

   always_comb begin
      stat_br_d  = stat_br_q;
      stat_mis_d = stat_mis_q;
      if (clear) begin
         stat_br_d  = '0;
         stat_mis_d = '0;
      end else if (run && resolve_valid) begin
         if (stat_br_q != 16'hFFFF) stat_br_d = stat_br_q + 16'd1;
         if (resolve_mispredict && (stat_mis_q != 16'hFFFF)) stat_mis_d = stat_mis_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_br_q  <= stat_br_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mis_q;
`else
   assign stat_branches    = 16'h0000;
   assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: sweep timing, saturation, speculative history, repair, collision, clear/reset, stats.
module tb_gshare_predictor;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] pc_id = 16'h0000;
   logic [3:0]  opcode_id = OP_ADD;
   logic        advance_id = 1'b0;
   logic        predict_taken;
   logic [3:0]  branch_hist_id;
   logic        ready;
   logic        resolve_valid = 1'b0;
   logic [15:0] pc_wb = 16'h0000;
   logic        resolve_taken = 1'b0;
   logic        resolve_mispredict = 1'b0;
   logic [3:0]  branch_hist_wb = 4'h0;
   logic [15:0] stat_branches;
   logic [15:0] stat_mispredicts;

   int n_checks = 0;
   int n_fail   = 0;

   gshare_predictor #(.INDEX_BITS(5), .HIST_BITS(4), .CTR_BITS(2)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .pc_id(pc_id), .opcode_id(opcode_id), .advance_id(advance_id),
      .predict_taken(predict_taken), .branch_hist_id(branch_hist_id), .ready(ready),
      .resolve_valid(resolve_valid), .pc_wb(pc_wb), .resolve_taken(resolve_taken),
      .resolve_mispredict(resolve_mispredict), .branch_hist_wb(branch_hist_wb),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until ready rises; gives up at 200.
   task automatic wait_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic resolve(input logic [15:0] pc, input logic [3:0] hist, input logic taken, input logic mis);
      resolve_valid      = 1'b1;
      pc_wb              = pc;
      branch_hist_wb     = hist;
      resolve_taken      = taken;
      resolve_mispredict = mis;
      tick();
      resolve_valid      = 1'b0;
      resolve_mispredict = 1'b0;
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      int n;
      pc_id = 16'h0000; opcode_id = OP_BR;
      #3;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
      n_checks++; if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL reset_predict: got %b want 0", predict_taken); end
      n_checks++; if (branch_hist_id !== 4'h0) begin n_fail++; $display("FAIL reset_hist: got %h want 0", branch_hist_id); end
      n_checks++; if (stat_branches !== 16'h0 || stat_mispredicts !== 16'h0) begin
         n_fail++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_branches, stat_mispredicts); end
      tick(); tick();
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_ready: got %b want 0", ready); end
      reset = 1'b1;
      wait_ready(n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL sweep_len: got %0d cycles want 32", n); end
   endtask

   task automatic test_sweep();
      opcode_id = OP_BR;
      for (int i = 0; i < 32; i++) begin
         pc_id = 16'(i << 1);
         #1;
         n_checks++; if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL sweep_entry%0d: got %b want 0", i, predict_taken); end
      end
      n_checks++; if (branch_hist_id !== 4'h0) begin n_fail++; $display("FAIL sweep_hist: got %h want 0", branch_hist_id); end
   endtask

   task automatic test_saturation();
      logic [3:0] exp_t, exp_nt;
      exp_t  = 4'b1111;   // 10,11,11,11
      exp_nt = 4'b0001;   // 10,01,00,00 (bit0 = first step)
      pc_id = 16'h0040; opcode_id = OP_BR; advance_id = 1'b0;
      for (int k = 0; k < 4; k++) begin
         resolve(16'h0040, 4'h0, 1'b1, 1'b0);
         n_checks++; if (predict_taken !== exp_t[k]) begin n_fail++; $display("FAIL sat_taken%0d: got %b want %b", k, predict_taken, exp_t[k]); end
      end
      for (int k = 0; k < 4; k++) begin
         resolve(16'h0040, 4'h0, 1'b0, 1'b0);
         n_checks++; if (predict_taken !== exp_nt[k]) begin n_fail++; $display("FAIL sat_nottaken%0d: got %b want %b", k, predict_taken, exp_nt[k]); end
      end
   endtask

   task automatic test_spec_history();
      logic [15:0] pcs [3];
      logic [2:0]  exp_p;
      logic [3:0]  exp_h [3];
      pcs[0] = 16'h0002; pcs[1] = 16'h0004; pcs[2] = 16'h0006;
      exp_p = 3'b101;
      exp_h[0] = 4'b0000; exp_h[1] = 4'b0001; exp_h[2] = 4'b0010;
      resolve(16'h0002, 4'h0, 1'b1, 1'b0);   // idx 1 -> 10
      resolve(16'h000E, 4'h0, 1'b1, 1'b0);   // idx 7 -> 10
      for (int k = 0; k < 3; k++) begin
         pc_id = pcs[k]; opcode_id = OP_BR; advance_id = 1'b1;
         #1;
         n_checks++; if (branch_hist_id !== exp_h[k]) begin n_fail++; $display("FAIL spec_hist_in%0d: got %b want %b", k, branch_hist_id, exp_h[k]); end
         n_checks++; if (predict_taken !== exp_p[2-k]) begin n_fail++; $display("FAIL spec_pred%0d: got %b want %b", k, predict_taken, exp_p[2-k]); end
         tick();
      end
      advance_id = 1'b0;
      #1;
      n_checks++; if (branch_hist_id !== 4'b0101) begin n_fail++; $display("FAIL spec_hist_final: got %b want 0101", branch_hist_id); end
      tick();
      n_checks++; if (branch_hist_id !== 4'b0101) begin n_fail++; $display("FAIL spec_hist_stall: got %b want 0101", branch_hist_id); end
      opcode_id = OP_ADD; advance_id = 1'b1;
      tick();
      advance_id = 1'b0;
      n_checks++; if (branch_hist_id !== 4'b0101) begin n_fail++; $display("FAIL spec_hist_nonbr: got %b want 0101", branch_hist_id); end
   endtask

   task automatic test_repair();
      resolve(16'h0010, 4'b0011, 1'b1, 1'b1);
      n_checks++; if (branch_hist_id !== 4'b0111) begin n_fail++; $display("FAIL repair_load: got %b want 0111", branch_hist_id); end
      pc_id = 16'h0004; opcode_id = OP_BR; advance_id = 1'b1;
      resolve(16'h0010, 4'b0010, 1'b1, 1'b1);
      advance_id = 1'b0;
      n_checks++; if (branch_hist_id !== 4'b0101) begin n_fail++; $display("FAIL repair_override: got %b want 0101", branch_hist_id); end
      resolve(16'h0010, 4'b1111, 1'b0, 1'b0);
      n_checks++; if (branch_hist_id !== 4'b0101) begin n_fail++; $display("FAIL repair_correct_br: got %b want 0101", branch_hist_id); end
   endtask

   task automatic test_collision();
      // hist 0101: pc 0x003C -> idx 30^10 = 20; pc_wb 0x0028 hist 0 -> idx 20 (still 01)
      pc_id = 16'h003C; opcode_id = OP_BR; advance_id = 1'b0;
      resolve_valid = 1'b1; pc_wb = 16'h0028; branch_hist_wb = 4'h0; resolve_taken = 1'b1; resolve_mispredict = 1'b0;
      #1;
      n_checks++; if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL collide_same_cycle: got %b want 0", predict_taken); end
      tick();
      resolve_valid = 1'b0;
      #1;
      n_checks++; if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL collide_next_cycle: got %b want 1", predict_taken); end
      pc_id = 16'hFFBD;
      #1;
      n_checks++; if (predict_taken !== 1'b1) begin n_fail++; $display("FAIL collide_upper_pc: got %b want 1", predict_taken); end
      opcode_id = OP_ADD;
      #1;
      n_checks++; if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL collide_nonbr: got %b want 0", predict_taken); end
   endtask

   task automatic test_clear_reset();
      int n;
      pulse_clear();
      n_checks++; if (ready !== 1'b0 || branch_hist_id !== 4'h0) begin
         n_fail++; $display("FAIL clear_run: got ready=%b hist=%b want 0/0000", ready, branch_hist_id); end
      wait_ready(n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL clear_sweep_len: got %0d want 32", n); end
      pc_id = 16'h0028; opcode_id = OP_BR;
      #1;
      n_checks++; if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL clear_reswept: got %b want 0", predict_taken); end
      pulse_clear();
      repeat (10) tick();
      pulse_clear();
      wait_ready(n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL clear_midsweep_len: got %0d want 32", n); end
      // resolves during the sweep must be ignored (entry 0 already swept)
      pulse_clear();
      repeat (5) tick();
      resolve_valid = 1'b1; pc_wb = 16'h0000; branch_hist_wb = 4'h0; resolve_taken = 1'b1; resolve_mispredict = 1'b1;
      repeat (3) tick();
      resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      n_checks++; if (branch_hist_id !== 4'h0 || ready !== 1'b0) begin
         n_fail++; $display("FAIL init_frozen: got hist=%b ready=%b want 0000/0", branch_hist_id, ready); end
      wait_ready(n);
      n_checks++; if (n !== 24) begin n_fail++; $display("FAIL init_remaining: got %0d want 24", n); end
      pc_id = 16'h0000; opcode_id = OP_BR;
      #1;
      n_checks++; if (predict_taken !== 1'b0) begin n_fail++; $display("FAIL init_no_train: got %b want 0", predict_taken); end
      n_checks++; if (stat_branches !== 16'h0) begin n_fail++; $display("FAIL init_no_stat: got %h want 0", stat_branches); end
      resolve(16'h0000, 4'b0111, 1'b1, 1'b1);
      n_checks++; if (branch_hist_id !== 4'b1111) begin n_fail++; $display("FAIL pre_reset_hist: got %b want 1111", branch_hist_id); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (ready !== 1'b0 || branch_hist_id !== 4'h0) begin
         n_fail++; $display("FAIL async_reset_run: got ready=%b hist=%b want 0/0000", ready, branch_hist_id); end
      @(posedge clk); #1 reset = 1'b1;
      wait_ready(n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL reset_run_len: got %0d want 32", n); end
      pulse_clear();
      repeat (7) tick();
      #2 reset = 1'b0;
      #1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_reset_sweep: got %b want 0", ready); end
      @(posedge clk); #1 reset = 1'b1;
      wait_ready(n);
      n_checks++; if (n !== 32) begin n_fail++; $display("FAIL reset_sweep_len: got %0d want 32", n); end
   endtask

   task automatic test_stats();
      logic [15:0] exp_b, exp_m;
      opcode_id = OP_ADD;
      resolve(16'h0002, 4'h0, 1'b1, 1'b0);
      resolve(16'h0002, 4'h0, 1'b0, 1'b1);
      resolve(16'h0002, 4'h0, 1'b1, 1'b0);
`ifdef BP_STATS_EN
      exp_b = 16'd3; exp_m = 16'd1;
`else
      exp_b = 16'd0; exp_m = 16'd0;
`endif
      n_checks++; if (stat_branches !== exp_b) begin n_fail++; $display("FAIL stat_br_count: got %h want %h", stat_branches, exp_b); end
      n_checks++; if (stat_mispredicts !== exp_m) begin n_fail++; $display("FAIL stat_mis_count: got %h want %h", stat_mispredicts, exp_m); end
`ifdef BP_STATS_EN
      resolve_valid = 1'b1; resolve_mispredict = 1'b1; pc_wb = 16'h0002; branch_hist_wb = 4'h0;
      repeat (65540) @(posedge clk);
      #1 resolve_valid = 1'b0; resolve_mispredict = 1'b0;
      n_checks++; if (stat_branches !== 16'hFFFF) begin n_fail++; $display("FAIL stat_br_sat: got %h want ffff", stat_branches); end
      n_checks++; if (stat_mispredicts !== 16'hFFFF) begin n_fail++; $display("FAIL stat_mis_sat: got %h want ffff", stat_mispredicts); end
`endif
      pulse_clear();
      n_checks++; if (stat_branches !== 16'h0 || stat_mispredicts !== 16'h0) begin
         n_fail++; $display("FAIL stat_clear: got %h/%h want 0/0", stat_branches, stat_mispredicts); end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_saturation();
      test_spec_history();
      test_repair();
      test_collision();
      test_clear_reset();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
